adc_sample_avg: RTL and testbench

- Decimating boxcar averager sitting directly downstream of ad7276_read.
- Consumes the 12-bit sample strobe (adc_data_en / adc_data) and accumulates 2^LOG2_N consecutive samples.
- Emits one rounded mean per window on a valid/ready output toward the heart-rate processing chain.
- Reduces sample rate and noise ahead of peak detection.

---
 rtl/adc_pkg.sv | 12 +
 rtl/adc_win_minmax.sv | 49 ++++
 rtl/adc_sample_avg.sv | 135 +++++++++++++
 tb/tb_adc_sample_avg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants and helpers for the ADC sample averaging path.
package adc_pkg;

    localparam int ADC_DATA_W     = 12;
    localparam int ADC_AVG_LOG2_N = 4;

    // An accumulator of data_w + log2_n bits holds 2^log2_n full-scale samples without wrapping.
    function automatic int acc_width(input int data_w, input int log2_n);
        return data_w + log2_n;
    endfunction

endpackage

// File: rtl/adc_win_minmax.sv
// Running min/max tracker for one averaging window.
// min_o/max_o present the extremes including the sample on sample_i this cycle,
// so the owner can capture them on the window's final strobe.
module adc_win_minmax
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              sample_en_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [DATA_W-1:0] min_o,
    output logic [DATA_W-1:0] max_o
);

    logic [DATA_W-1:0] min_q;
    logic [DATA_W-1:0] max_q;

    // Fold the current sample into the window extremes; the first sample reloads them.
    always_comb begin
        min_o = min_q;
        max_o = max_q;
        if (start_i) begin
            min_o = sample_i;
            max_o = sample_i;
        end else begin
            if (sample_i < min_q) min_o = sample_i;
            if (sample_i > max_q) max_o = sample_i;
        end
    end

    // Trackers advance on every accepted sample and restart on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '0;
            max_q <= '0;
        end else if (clear_i) begin
            min_q <= '0;
            max_q <= '0;
        end else if (sample_en_i) begin
            min_q <= min_o;
            max_q <= max_o;
        end
    end

endmodule

// File: rtl/adc_sample_avg.sv
// Decimating boxcar averager: sums 2^LOG2_N ADC samples and emits the
// round-half-up mean on a valid/ready port. Newest result wins if the
// consumer stalls; avg_ovf records that a result was lost.
// Optional feature macro ADC_AVG_MINMAX_EN adds win_min/win_max outputs.
module adc_sample_avg
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W,
    parameter int LOG2_N = ADC_AVG_LOG2_N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adc_data_en,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              clear,
    output logic              avg_valid,
    input  logic              avg_ready,
    output logic [DATA_W-1:0] avg_data,
    output logic              avg_ovf,
    output logic [LOG2_N-1:0] win_cnt
`ifdef ADC_AVG_MINMAX_EN
    ,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max
`endif
);

    localparam int                ACC_W = acc_width(DATA_W, LOG2_N);
    localparam logic [LOG2_N-1:0] LAST  = {LOG2_N{1'b1}};
    localparam logic [ACC_W-1:0]  HALF  = ACC_W'(2 ** (LOG2_N - 1));

    // Round half up and divide by the window length; the biased sum cannot exceed ACC_W bits.
    function automatic logic [DATA_W-1:0] round_mean(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] biased;
        biased = sum + HALF;
        return biased[ACC_W-1:LOG2_N];
    endfunction

    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic [LOG2_N-1:0] cnt_q,   cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ovf_q,   ovf_d;
    logic [ACC_W-1:0]  sum_w;
    logic              complete;

    assign sum_w    = acc_q + ACC_W'(adc_data);
    assign complete = adc_data_en && !clear && (cnt_q == LAST);

    // Next-state for accumulator, window counter and the result/handshake registers.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (clear) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            if (valid_q && avg_ready) valid_d = 1'b0;
            if (adc_data_en) begin
                if (cnt_q == LAST) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    data_d  = round_mean(sum_w);
                    valid_d = 1'b1;
                    if (valid_q && !avg_ready) ovf_d = 1'b1;
                end else begin
                    acc_d = sum_w;
                    cnt_d = cnt_q + LOG2_N'(1);
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign avg_valid = valid_q;
    assign avg_data  = data_q;
    assign avg_ovf   = ovf_q;
    assign win_cnt   = cnt_q;

`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] run_min;
    logic [DATA_W-1:0] run_max;
    logic [DATA_W-1:0] win_min_q;
    logic [DATA_W-1:0] win_max_q;

    adc_win_minmax #(
        .DATA_W (DATA_W)
    ) u_minmax (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .sample_en_i (adc_data_en),
        .start_i     (cnt_q == '0),
        .sample_i    (adc_data),
        .min_o       (run_min),
        .max_o       (run_max)
    );

    // Window extremes are published alongside avg_data and share its overwrite rule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_min_q <= '0;
            win_max_q <= '0;
        end else if (complete) begin
            win_min_q <= run_min;
            win_max_q <= run_max;
        end
    end

    assign win_min = win_min_q;
    assign win_max = win_max_q;
`endif

endmodule

// File: tb/tb_adc_sample_avg.sv
// Testbench for adc_sample_avg: directed scenarios plus randomized traffic,
// compared every cycle against a window-queue reference model.
module tb_adc_sample_avg;

    localparam int DATA_W = 12;
    localparam int LOG2_N = 4;
    localparam int N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              adc_data_en = 1'b0;
    logic [DATA_W-1:0] adc_data = '0;
    logic              clear = 1'b0;
    logic              avg_ready = 1'b0;
    logic              avg_valid;
    logic [DATA_W-1:0] avg_data;
    logic              avg_ovf;
    logic [LOG2_N-1:0] win_cnt;
`ifdef ADC_AVG_MINMAX_EN
    logic [DATA_W-1:0] win_min;
    logic [DATA_W-1:0] win_max;
`endif

    int n_chk = 0;
    int n_err = 0;

    adc_sample_avg #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .adc_data_en (adc_data_en),
        .adc_data    (adc_data),
        .clear       (clear),
        .avg_valid   (avg_valid),
        .avg_ready   (avg_ready),
        .avg_data    (avg_data),
        .avg_ovf     (avg_ovf),
        .win_cnt     (win_cnt)
`ifdef ADC_AVG_MINMAX_EN
        ,
        .win_min     (win_min),
        .win_max     (win_max)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the current window is a queue of raw samples.
    int          win_q[$];
    logic        exp_valid = 1'b0;
    int          exp_data  = 0;
    logic        exp_ovf   = 1'b0;
    int          exp_min   = 0;
    int          exp_max   = 0;
    int          m_sum, m_min, m_max;
    logic        m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q.delete();
            exp_valid = 1'b0;
            exp_data  = 0;
            exp_ovf   = 1'b0;
            exp_min   = 0;
            exp_max   = 0;
        end else if (clear) begin
            win_q.delete();
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
        end else begin
            m_done = adc_data_en && (win_q.size() == N - 1);
            if (m_done && exp_valid && !avg_ready) exp_ovf = 1'b1;
            if (exp_valid && avg_ready) exp_valid = 1'b0;
            if (adc_data_en) win_q.push_back(int'(adc_data));
            if (m_done) begin
                m_sum = 0;
                m_min = win_q[0];
                m_max = win_q[0];
                foreach (win_q[i]) begin
                    m_sum += win_q[i];
                    if (win_q[i] < m_min) m_min = win_q[i];
                    if (win_q[i] > m_max) m_max = win_q[i];
                end
                exp_data  = (m_sum + N / 2) / N;
                exp_min   = m_min;
                exp_max   = m_max;
                exp_valid = 1'b1;
                win_q.delete();
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        chk("avg_valid", int'(avg_valid), int'(exp_valid));
        chk("avg_data",  int'(avg_data),  exp_data);
        chk("avg_ovf",   int'(avg_ovf),   int'(exp_ovf));
        chk("win_cnt",   int'(win_cnt),   win_q.size());
`ifdef ADC_AVG_MINMAX_EN
        chk("win_min",   int'(win_min),   exp_min);
        chk("win_max",   int'(win_max),   exp_max);
`endif
    end

    task automatic step(input logic en, input logic [DATA_W-1:0] d,
                        input logic clr, input logic rdy);
        adc_data_en = en;
        adc_data    = d;
        clear       = clr;
        avg_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int cnt, input logic [DATA_W-1:0] d, input logic rdy);
        for (int i = 0; i < cnt; i++) step(1'b1, d, 1'b0, rdy);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(avg_valid), 0);
        chk("reset_data",  int'(avg_data),  0);
        chk("reset_ovf",   int'(avg_ovf),   0);
        chk("reset_cnt",   int'(win_cnt),   0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0, 1'b1);

        // Constant window, consumer always ready.
        burst(15, 12'hA55, 1'b1);
        chk("a55_not_yet", int'(avg_valid), 0);
        burst(1, 12'hA55, 1'b1);
        chk("a55_valid", int'(avg_valid), 1);
        chk("a55_data",  int'(avg_data),  12'hA55);
        chk("a55_ovf",   int'(avg_ovf),   0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("a55_drop",  int'(avg_valid), 0);

        // Ramp, then full-scale window back to back.
        for (int i = 0; i < N; i++) step(1'b1, DATA_W'(i), 1'b0, 1'b1);
        chk("ramp_data", int'(avg_data), 8);
        chk("ramp_cnt0", int'(win_cnt),  0);
        step(1'b1, 12'hFFF, 1'b0, 1'b1);
        chk("fff_cnt1",  int'(win_cnt),  1);
        burst(N - 1, 12'hFFF, 1'b1);
        chk("fff_data",  int'(avg_data), 12'hFFF);
        step(1'b0, '0, 1'b0, 1'b1);

        // Stalled consumer across two windows.
        burst(N, 12'h100, 1'b0);
        chk("stall1_data", int'(avg_data), 12'h100);
        chk("stall1_ovf",  int'(avg_ovf),  0);
        burst(N, 12'h200, 1'b0);
        chk("stall2_valid", int'(avg_valid), 1);
        chk("stall2_data",  int'(avg_data),  12'h200);
        chk("stall2_ovf",   int'(avg_ovf),   1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("stall_xfer_valid", int'(avg_valid), 0);
        chk("stall_ovf_sticky", int'(avg_ovf),   1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("stall_ovf_held",   int'(avg_ovf),   1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("clear_ovf",        int'(avg_ovf),   0);

        // Clear coinciding with a strobe discards the partial window.
        burst(7, 12'h123, 1'b1);
        step(1'b1, 12'hFFF, 1'b1, 1'b1);
        chk("clear_cnt", int'(win_cnt), 0);
        burst(N - 1, 12'h010, 1'b1);
        chk("clear_no_early", int'(avg_valid), 0);
        burst(1, 12'h010, 1'b1);
        chk("clear_valid", int'(avg_valid), 1);
        chk("clear_data",  int'(avg_data),  12'h010);

        // Asynchronous reset in the middle of a window.
        burst(9, 12'h300, 1'b0);
        chk("pre_rst_cnt", int'(win_cnt), 9);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", int'(avg_valid), 0);
        chk("arst_data",  int'(avg_data),  0);
        chk("arst_ovf",   int'(avg_ovf),   0);
        chk("arst_cnt",   int'(win_cnt),   0);
`ifdef ADC_AVG_MINMAX_EN
        chk("arst_min",   int'(win_min),   0);
        chk("arst_max",   int'(win_max),   0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        burst(N, 12'h7FF, 1'b1);
        chk("post_rst_data", int'(avg_data), 12'h7FF);
        step(1'b0, '0, 1'b0, 1'b1);

        // Mixed window with distinct extremes.
        step(1'b1, 12'h003, 1'b0, 1'b1);
        step(1'b1, 12'hF00, 1'b0, 1'b1);
        burst(N - 2, 12'h100, 1'b1);
        chk("mix_data", int'(avg_data), 12'h1D0);
`ifdef ADC_AVG_MINMAX_EN
        chk("mix_min",  int'(win_min),  12'h003);
        chk("mix_max",  int'(win_max),  12'hF00);
`endif
        step(1'b0, '0, 1'b0, 1'b1);

        // Randomized traffic: strobes, stalls, occasional clears and extremes.
        for (int i = 0; i < 2000; i++) begin
            logic [DATA_W-1:0] d;
            case ($urandom_range(0, 7))
                0:       d = '0;
                1:       d = '1;
                default: d = DATA_W'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), d,
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0));
        end

        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
